// File: rtl/if_stage_pkg.sv
// Shared types and constants for the MINAv2 instruction fetch stage.
package if_stage_pkg;
  localparam int INSN_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] ia_plus_4;
    logic [INSN_WIDTH-1:0] ir;
  } id_params_t;

  typedef enum logic {IF_IDLE, IF_FETCH} if_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry in-order FIFO of id_params_t; flush dominates push and pop.
module fetch_buffer
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  id_params_t       push_data,
  input  logic             pop,
  input  logic             flush,
  output id_params_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  id_params_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/if_stage.sv
// MINAv2 instruction fetch: owns the PC, pipelines imem requests, buffers
// in-order responses and drops wrong-path responses after an EX redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output id_params_t  id_params
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  if_state_t        state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] in_flight_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   occupancy;
  logic             hs;
  logic             rsp_ok;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             buf_full;
  logic             buf_empty;
  logic             buf_pop;
  id_params_t       push_data;

  // Address queue: ia_plus_4 of every accepted right-path request, in order.
  logic [31:0]      aq [DEPTH];
  logic [PTR_W-1:0] aq_rd;
  logic [PTR_W-1:0] aq_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign occupancy      = {1'b0, in_flight} + {1'b0, buf_count};
  assign imem_req_valid = (state == IF_FETCH) && (occupancy < (CNT_W+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (in_flight != '0);
  assign rsp_drop       = rsp_ok && (discard != '0);
  assign rsp_keep       = rsp_ok && (discard == '0);
  assign buf_pop        = !buf_empty && !stall;
  assign push_data      = '{ia_plus_4: aq[aq_rd], ir: imem_rsp_data};
  assign id_valid       = !buf_empty;

  always_comb begin
    in_flight_next = in_flight;
    if (hs)     in_flight_next = in_flight_next + CNT_W'(1);
    if (rsp_ok) in_flight_next = in_flight_next - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      pc        <= RESET_VECTOR;
      in_flight <= '0;
      discard   <= '0;
      aq_rd     <= '0;
      aq_wr     <= '0;
    end else begin
      case (state)
        IF_IDLE:  state <= IF_FETCH;
        default:  state <= IF_FETCH;
      endcase
      in_flight <= in_flight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        pc      <= {redirect_addr[31:2], 2'b00};
        discard <= in_flight_next;
        aq_rd   <= '0;
        aq_wr   <= '0;
      end else begin
        if (hs) begin
          pc    <= pc + 32'd4;
          aq_wr <= ptr_inc(aq_wr);
        end
        if (rsp_drop) discard <= discard - CNT_W'(1);
        if (rsp_keep) aq_rd <= ptr_inc(aq_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs && !redirect_valid) aq[aq_wr] <= pc + 32'd4;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (push_data),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .head      (id_params),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (in_flight != '0));
  assert property (@(posedge clk) disable iff (rst) rsp_keep |-> !buf_full);
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: in-order memory model with random latency,
// sequential-stream reference restarted on every redirect, scoreboard monitor.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RV     = 32'h0000_0000;
  localparam int          NCYC   = 4000;
  localparam int          WINDOW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  id_params_t  id_params;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  id_params_t  exp_q[$];
  logic [31:0] exp_req_q[$];
  pend_t       mem_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  if_stage #(.RESET_VECTOR(RV), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_params      (id_params)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Expected architectural stream: sequential words from the fetch target.
  task automatic restart_stream(input logic [31:0] target);
    logic [31:0] a;
    exp_q.delete();
    exp_req_q.delete();
    a = {target[31:2], 2'b00};
    for (int i = 0; i < WINDOW; i++) begin
      exp_q.push_back('{ia_plus_4: a + 32'd4, ir: word_at(a)});
      exp_req_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Driver and memory model
  initial begin
    int since;
    int nredir;
    #1;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    restart_stream(RV);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    since = 0;
    nredir = 0;
    for (int c = 0; c < NCYC + 10; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_q.size() > 0 && mem_q[0].due <= c) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = (c >= 6) && ($urandom_range(0, 99) < 70);
      stall = (c >= 6) && ($urandom_range(0, 99) < 25);
      since++;
      redirect_valid = (c >= 12) && (($urandom_range(0, 99) < 3) || since >= 150);
      if (redirect_valid) begin
        since = 0;
        case (nredir)
          0:       redirect_addr = 32'h0000_0103;
          1:       redirect_addr = 32'hFFFF_FFFC;
          default: redirect_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) : $urandom;
        endcase
        nredir++;
      end
      #1;
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, due: c + $urandom_range(1, 3)});
      #2;
      if (redirect_valid) restart_stream(redirect_addr);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_redirect;
    int          idle;
    int          consumed;
    id_params_t  e;
    #3;
    check("rst_req_valid", 64'(imem_req_valid), 64'(0));
    check("rst_id_valid", 64'(id_valid), 64'(0));
    check("rst_id_params", 64'(id_params), 64'(0));
    check("rst_req_addr", 64'(imem_req_addr), 64'(RV));
    wait (rst == 1'b0);
    #2;
    prev_redirect = 1'b0;
    idle = 0;
    consumed = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #2;
      end
      if (cyc == 0) check("idle_no_req", 64'(imem_req_valid), 64'(0));
      if (cyc >= 1 && cyc <= 5) begin
        check("nordy_req_valid", 64'(imem_req_valid), 64'(1));
        check("nordy_req_addr", 64'(imem_req_addr), 64'(RV));
        check("nordy_id_valid", 64'(id_valid), 64'(0));
      end
      if (prev_redirect) check("redir_flush_id_valid", 64'(id_valid), 64'(0));
      if (redirect_valid) check("redir_req_suppressed", 64'(imem_req_valid), 64'(0));
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) check("req_addr_underflow", 64'(imem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("req_addr", 64'(imem_req_addr), 64'(exp_req_q.pop_front()));
      end
      if (id_valid && !stall) begin
        idle = 0;
        consumed++;
        if (exp_q.size() == 0) check("id_params_underflow", 64'(id_params), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("id_params", 64'(id_params), 64'(e));
        end
      end else begin
        idle++;
        if (idle > 300) begin
          check("progress_timeout", 64'(idle), 64'(0));
          idle = 0;
        end
      end
      prev_redirect = redirect_valid;
    end
    n_tests++;
    if (consumed < 200) begin
      n_fail++;
      $display("FAIL throughput: consumed %0d required at least 200", consumed);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
